psum_window_acc: RTL

Parametrised, multi-lane sliding/block partial-sum accumulator for the convolution datapath. It sits between the PE array column outputs and the output buffer. Each lane sums the last WIN partial sums, for example the WIN kernel-row contributions of one output pixel. Each lane keeps a ring buffer and a running sum, and all lanes share valid/ready handshakes. Window length, lane count and widths are parameters; sliding or block windowing is selected at run time.

---
 rtl/psum_acc_pkg.sv | 35 +++
 rtl/psum_lane.sv | 87 ++++++++
 rtl/psum_window_acc.sv | 116 +++++++++++
 3 files changed

// File: rtl/psum_acc_pkg.sv
// Shared constants and helpers for the partial-sum window accumulator.
// sat_conv is only referenced when PSUM_ACC_SAT_EN is defined.
package psum_acc_pkg;

   localparam logic MODE_SLIDE = 1'b0;
   localparam logic MODE_BLOCK = 1'b1;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Clamp a sign-extended sum into a signed out_w-bit range; flag reports clamping.
   function automatic logic signed [63:0] sat_conv(input logic signed [63:0] v,
                                                   input int out_w,
                                                   output logic flag);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      flag = 1'b0;
      if (v > hi) begin
         flag = 1'b1;
         return hi;
      end
      if (v < lo) begin
         flag = 1'b1;
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: ring buffer of the last WIN inputs, exact running sum,
// and the registered output conversion (saturating with PSUM_ACC_SAT_EN, else wrapping).
module psum_lane
   import psum_acc_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16,
   parameter int WIN   = 3,
   parameter int ACC_W = 18,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             flush,
   input  logic             beat,
   input  logic             full,
   input  logic             clr,
   input  logic             load,
   input  logic [PW-1:0]    wp,
   input  logic [IN_W-1:0]  psum,
   output logic [OUT_W-1:0] acc_out
`ifdef PSUM_ACC_SAT_EN
   ,
   output logic             sat_flag
`endif
);

   logic [IN_W-1:0]         ring_q [WIN];
   logic [IN_W-1:0]         ring_d [WIN];
   logic [IN_W-1:0]         old_val;
   logic signed [ACC_W-1:0] sum_q, sum_d, sum_new;
   logic [OUT_W-1:0]        acc_q, acc_d;
`ifdef PSUM_ACC_SAT_EN
   logic                    sat_q, sat_d;
   logic signed [63:0]      wide;
`endif

   always_comb begin
      ring_d  = ring_q;
      sum_d   = sum_q;
      acc_d   = acc_q;
      // Once the window is full the slot under wp holds the sample leaving the window.
      old_val = full ? ring_q[wp] : '0;
      sum_new = sum_q + {{(ACC_W-IN_W){psum[IN_W-1]}}, psum}
                      - {{(ACC_W-IN_W){old_val[IN_W-1]}}, old_val};
`ifdef PSUM_ACC_SAT_EN
      sat_d   = sat_q;
      wide    = {{(64-ACC_W){sum_new[ACC_W-1]}}, sum_new};
`endif
      if (beat) begin
         ring_d[wp] = psum;
         sum_d      = clr ? '0 : sum_new;
      end
      if (load) begin
`ifdef PSUM_ACC_SAT_EN
         acc_d = OUT_W'(sat_conv(wide, OUT_W, sat_d));
`else
         acc_d = OUT_W'(sum_new);
`endif
      end
   end

   always_ff @(posedge clk) begin
      ring_q <= ring_d;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         sum_q <= '0;
         acc_q <= '0;
`ifdef PSUM_ACC_SAT_EN
         sat_q <= 1'b0;
`endif
      end else begin
         sum_q <= sum_d;
         acc_q <= acc_d;
`ifdef PSUM_ACC_SAT_EN
         sat_q <= sat_d;
`endif
      end
   end

   assign acc_out = acc_q;
`ifdef PSUM_ACC_SAT_EN
   assign sat_flag = sat_q;
`endif

endmodule

// File: rtl/psum_window_acc.sv
// Multi-lane sliding/block window partial-sum accumulator with a single output register.
// Optional saturation and sat_flag port are enabled by PSUM_ACC_SAT_EN.
module psum_window_acc
   import psum_acc_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16,
   parameter int WIN   = 3,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   block_mode,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  psum_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] accum_out
`ifdef PSUM_ACC_SAT_EN
   ,
   output logic [LANES-1:0]       sat_flag
`endif
);

   localparam int ACC_W = IN_W + clog2(WIN);
   localparam int PW    = clog2(WIN);
   localparam int FW    = clog2(WIN + 1);
   localparam logic [FW-1:0] WIN_F   = FW'(WIN);
   localparam logic [PW-1:0] WP_LAST = PW'(WIN - 1);

   logic [FW-1:0] fill_q, fill_d, fill_post;
   logic [PW-1:0] wp_q, wp_d;
   logic          mode_q, mode_d, mode_eff;
   logic          out_valid_q, out_valid_d;
   logic          flush, accept, full, complete, blk_clr;

   always_comb begin
      flush     = rst || !en;
      in_ready  = !out_valid_q || out_ready;
      accept    = in_valid && in_ready && !flush;
      full      = (fill_q == WIN_F);
      fill_post = full ? fill_q : fill_q + FW'(1);
      // block_mode only matters on the beat that opens a window.
      mode_eff  = (fill_q == '0) ? block_mode : mode_q;
      complete  = accept && (fill_post == WIN_F);
      blk_clr   = complete && (mode_eff == MODE_BLOCK);

      fill_d      = fill_q;
      wp_d        = wp_q;
      mode_d      = mode_q;
      out_valid_d = out_valid_q;

      if (accept) begin
         fill_d = fill_post;
         wp_d   = (wp_q == WP_LAST) ? '0 : wp_q + PW'(1);
         if (fill_q == '0) mode_d = block_mode;
         if (blk_clr) begin
            fill_d = '0;
            wp_d   = '0;
         end
      end

      if (complete)       out_valid_d = 1'b1;
      else if (out_ready) out_valid_d = 1'b0;

      if (flush) begin
         fill_d      = '0;
         wp_d        = '0;
         mode_d      = MODE_SLIDE;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q      <= '0;
         wp_q        <= '0;
         mode_q      <= MODE_SLIDE;
         out_valid_q <= 1'b0;
      end else begin
         fill_q      <= fill_d;
         wp_q        <= wp_d;
         mode_q      <= mode_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      psum_lane #(
         .IN_W (IN_W),
         .OUT_W(OUT_W),
         .WIN  (WIN),
         .ACC_W(ACC_W),
         .PW   (PW)
      ) u_lane (
         .clk     (clk),
         .flush   (flush),
         .beat    (accept),
         .full    (full),
         .clr     (blk_clr),
         .load    (complete),
         .wp      (wp_q),
         .psum    (psum_in[i*IN_W +: IN_W]),
         .acc_out (accum_out[i*OUT_W +: OUT_W])
`ifdef PSUM_ACC_SAT_EN
         ,
         .sat_flag(sat_flag[i])
`endif
      );
   end

endmodule
